// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - in-order pipeline valid/stall/flush/hazard control with perf counters
// Define PIPE_CTRL_FWD_EN when a forwarding network exists: only load-use hazards then stall issue.
module pipe_ctrl #(
  parameter int STAGES      = 4,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_STAGE   = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  input  logic                  issue_wback,
  input  logic                  issue_load,
  input  logic                  flush,
  input  logic                  mem_busy,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES-1:0]     stage_en,
  output logic                  hazard,
  output logic                  retire_valid,
  output logic [REG_ADDR_W-1:0] retire_rd,
  output logic                  retire_wback,
  output logic [31:0]           retire_cnt,
  output logic [31:0]           stall_cnt
);

  logic [STAGES-1:0]     r_valid;
  logic [STAGES-1:0]     r_wback;
  logic [STAGES-1:0]     r_load;
  logic [REG_ADDR_W-1:0] r_rd [STAGES];
  logic                  w_stall;
  logic [STAGES-1:0]     w_hold;
  logic                  w_match1;
  logic                  w_match2;
  logic                  w_accept;
  logic                  w_unused_load;

  assign w_stall = mem_busy & r_valid[MEM_STAGE];

  always_comb begin
    w_hold = '0;
    for (int i = 0; i <= MEM_STAGE; i++) w_hold[i] = w_stall;
  end

  always_comb begin
    w_match1 = 1'b0;
    w_match2 = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
    if (r_valid[0] && r_wback[0] && r_load[0]) begin
      w_match1 = (r_rd[0] == issue_rs1);
      w_match2 = (r_rd[0] == issue_rs2);
    end
`else
    // The writeback stage is excluded: its result is visible to the register read this cycle.
    for (int j = 0; j < STAGES-1; j++) begin
      if (r_valid[j] && r_wback[j]) begin
        if (r_rd[j] == issue_rs1) w_match1 = 1'b1;
        if (r_rd[j] == issue_rs2) w_match2 = 1'b1;
      end
    end
`endif
  end

`ifdef PIPE_CTRL_FWD_EN
  assign w_unused_load = ^r_load[STAGES-1:1];
`else
  assign w_unused_load = ^r_load;
`endif

  assign hazard = issue_valid &
                  ((issue_use1 & (issue_rs1 != '0) & w_match1) |
                   (issue_use2 & (issue_rs2 != '0) & w_match2));
  assign issue_ready  = ~w_hold[0] & ~hazard & ~flush;
  assign w_accept     = issue_valid & issue_ready;
  assign stage_en     = ~w_hold;
  assign stage_valid  = r_valid;
  assign retire_valid = r_valid[STAGES-1];
  assign retire_rd    = r_rd[STAGES-1];
  assign retire_wback = r_wback[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_wback <= '0;
      r_load  <= '0;
      for (int i = 0; i < STAGES; i++) r_rd[i] <= '0;
    end else begin
      if (flush) r_valid[0] <= 1'b0;
      else if (!w_hold[0]) r_valid[0] <= w_accept;
      if (!w_hold[0]) begin
        r_rd[0]    <= w_accept ? issue_rd : '0;
        r_wback[0] <= w_accept & issue_wback;
        r_load[0]  <= w_accept & issue_load;
      end
      // Flush wins over hold; the stage just past a held memory stage takes a bubble.
      for (int i = 1; i < STAGES; i++) begin
        if (flush && i < FLUSH_DEPTH) r_valid[i] <= 1'b0;
        else if (!w_hold[i]) r_valid[i] <= (i == MEM_STAGE+1 && w_stall) ? 1'b0 : r_valid[i-1];
        if (!w_hold[i]) begin
          r_rd[i] <= r_rd[i-1];
          if (i == MEM_STAGE+1 && w_stall) begin
            r_wback[i] <= 1'b0;
            r_load[i]  <= 1'b0;
          end else begin
            r_wback[i] <= r_wback[i-1];
            r_load[i]  <= r_load[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire_valid) retire_cnt <= retire_cnt + 32'd1;
      if (issue_valid && !issue_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (default parameters)
module tb_pipe_ctrl;
  localparam int RW = 5;

`ifdef PIPE_CTRL_FWD_EN
  localparam int EXP_GAP = 0, EXP_LD = 1, EXP_ALU = 0;
`else
  localparam int EXP_GAP = 2, EXP_LD = 3, EXP_ALU = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_ready;
  logic [RW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_use1, issue_use2, issue_wback, issue_load;
  logic          flush, mem_busy;
  logic [3:0]    stage_valid, stage_en;
  logic          hazard, retire_valid, retire_wback;
  logic [RW-1:0] retire_rd;
  logic [31:0]   retire_cnt, stall_cnt;

  logic [RW:0]   sb_q [$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            exp_retire = 0;
  int            exp_stall = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .issue_wback(issue_wback), .issue_load(issue_load),
    .flush(flush), .mem_busy(mem_busy),
    .stage_valid(stage_valid), .stage_en(stage_en), .hazard(hazard),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wback(retire_wback),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && retire_valid) begin
      if (sb_q.size() == 0) begin
        chk("retire_nothing_pending", {31'd0, retire_valid}, 32'd0);
      end else begin
        logic [RW:0] e;
        e = sb_q.pop_front();
        chk("retire_rd", {27'd0, retire_rd}, {27'd0, e[RW-1:0]});
        chk("retire_wback", {31'd0, retire_wback}, {31'd0, e[RW]});
      end
    end
  end

  // One cycle: inputs change 1 time unit after the rising edge, outputs are read at the falling edge.
  task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic u1, input logic u2,
                       input logic wb, input logic ld, input logic fl, input logic mb,
                       input logic keep);
    @(posedge clk);
    #1;
    issue_valid = v;  issue_rs1 = rs1;  issue_rs2 = rs2;  issue_rd = rd;
    issue_use1 = u1;  issue_use2 = u2;  issue_wback = wb; issue_load = ld;
    flush = fl;       mem_busy = mb;
    @(negedge clk);
    if (v && issue_ready && keep) begin
      sb_q.push_back({wb, rd});
      exp_retire++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stage_valid"}, {28'd0, stage_valid}, 32'd0);
    chk({tag, "_retire_valid"}, {31'd0, retire_valid}, 32'd0);
    chk({tag, "_retire_rd"}, {27'd0, retire_rd}, 32'd0);
    chk({tag, "_retire_wback"}, {31'd0, retire_wback}, 32'd0);
    chk({tag, "_retire_cnt"}, retire_cnt, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_stage_en"}, {28'd0, stage_en}, 32'hF);
    chk({tag, "_hazard"}, {31'd0, hazard}, 32'd0);
  endtask

  task automatic run_pair(input string tag, input logic [RW-1:0] prd, input logic pld, input int gap,
                          input logic [RW-1:0] crs1, input logic cu1,
                          input logic [RW-1:0] crs2, input logic cu2, input int exp_hz);
    int hz;
    bit done;
    hz = 0;
    done = 1'b0;
    drive(1'b1, '0, '0, prd, 1'b0, 1'b0, 1'b1, pld, 1'b0, 1'b0, 1'b1);
    chk({tag, "_prod_ready"}, {31'd0, issue_ready}, 32'd1);
    idle(gap);
    for (int k = 0; k < 10 && !done; k++) begin
      drive(1'b1, crs1, crs2, 5'd20, cu1, cu2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (hazard) hz++;
      if (issue_ready) done = 1'b1;
    end
    chk({tag, "_accepted"}, {31'd0, done}, 32'd1);
    chk({tag, "_hazard_cycles"}, hz, exp_hz);
    exp_stall += exp_hz;
    idle(6);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
  endtask

  initial begin
    int first_ret, last_ret;
    rst = 1'b1;
    issue_valid = 1'b1; issue_rs1 = 5'd3; issue_rs2 = '0; issue_rd = 5'd3;
    issue_use1 = 1'b1;  issue_use2 = 1'b0; issue_wback = 1'b1; issue_load = 1'b0;
    flush = 1'b0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_valid = 1'b0;

    // Six independent back-to-back issues.
    first_ret = 0;
    last_ret = 0;
    for (int c = 1; c <= 12; c++) begin
      drive(c <= 6, '0, '0, 5'(c + 10), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c <= 6) chk("b2b_ready", {31'd0, issue_ready}, 32'd1);
      if (retire_valid) begin
        if (first_ret == 0) first_ret = c;
        last_ret = c;
      end
    end
    chk("b2b_first_retire", first_ret, 32'd5);
    chk("b2b_last_retire", last_ret, 32'd10);
    chk("b2b_retire_cnt", retire_cnt, exp_retire);
    chk("b2b_stall_cnt", stall_cnt, 32'd0);

    run_pair("raw_gap", 5'd3, 1'b0, 1, 5'd3, 1'b1, 5'd0, 1'b0, EXP_GAP);
    run_pair("lu_load", 5'd5, 1'b1, 0, 5'd0, 1'b0, 5'd5, 1'b1, EXP_LD);
    run_pair("lu_alu",  5'd6, 1'b0, 0, 5'd6, 1'b1, 5'd0, 1'b0, EXP_ALU);
    run_pair("x0",      5'd0, 1'b1, 0, 5'd0, 1'b1, 5'd0, 1'b1, 0);
    run_pair("unused",  5'd7, 1'b1, 0, 5'd7, 1'b0, 5'd7, 1'b0, 0);

    // Memory stall for 3 cycles with all four stages full.
    for (int k = 0; k < 4; k++)
      drive(1'b1, '0, '0, 5'(8 + k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, '0, '0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mem_stage_en", {28'd0, stage_en}, 32'h8);
      chk("mem_ready", {31'd0, issue_ready}, 32'd0);
      chk("mem_stage_valid", {28'd0, stage_valid}, (k == 0) ? 32'hF : 32'h7);
      if (k > 0) chk("mem_bubble", {31'd0, retire_valid}, 32'd0);
    end
    exp_stall += 3;
    drive(1'b1, '0, '0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mem_release_ready", {31'd0, issue_ready}, 32'd1);
    idle(8);
    chk("mem_stall_cnt", stall_cnt, exp_stall);
    chk("mem_retire_cnt", retire_cnt, exp_retire);

    // Flush and memory stall in the same cycle.
    drive(1'b1, '0, '0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, '0, '0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    exp_stall += 1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_young_cleared", {30'd0, stage_valid[1:0]}, 32'd0);
    chk("flush_mem_kept", {31'd0, stage_valid[2]}, 32'd1);
    chk("flush_stage_en", {29'd0, stage_en[2:0]}, 32'd0);
    idle(8);
    chk("flush_stall_cnt", stall_cnt, exp_stall);
    chk("flush_retire_cnt", retire_cnt, exp_retire);

    // Reset pulsed in the middle of a stall.
    drive(1'b1, '0, '0, 5'd17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 5'd18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 5'd19, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd17, '0, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_pre_stage_valid", {28'd0, stage_valid}, 32'h7);
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    exp_retire = 0;
    exp_stall = 0;
    chk_cleared("rst_mid");
    #1;
    rst = 1'b0;
    issue_rd = 5'd22;
    issue_use1 = 1'b0;
    #1;
    chk("rst_after_ready", {31'd0, issue_ready}, 32'd1);
    sb_q.push_back({1'b1, 5'd22});
    exp_retire++;
    @(posedge clk);
    #1;
    chk("rst_after_valid0", {28'd0, stage_valid}, 32'h1);
    issue_valid = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    idle(6);
    chk("rst_after_retire_cnt", retire_cnt, exp_retire);
    chk("rst_after_stall_cnt", stall_cnt, exp_stall);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
